col_parity: RTL and testbench

- Keccak theta step engine working over a slice-organised state memory.
- The memory holds 64 words of 25 bits; each word is one slice z (bits x,y with x,y in 0..4).
- On start, the block makes two passes over memory. Pass 1 computes the column parities; pass 2 writes each slice back XORed with the theta mask. It then raises done.
- Sits between the top-level round controller and the shared state Memory on its 25-bit port.

---
 rtl/col_parity_pkg.sv | 29 ++
 rtl/col_parity_theta_mask_gen.sv | 26 ++
 rtl/col_parity.sv | 109 ++++++++++
 tb/tb_col_parity.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/col_parity_pkg.sv
// ============================================================================
// col_parity_pkg
// Shared constants, FSM state type and bit-index helper for the Keccak
// theta engine (col_parity) and its mask generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package col_parity_pkg;

  localparam int SLICES    = 64;  // number of slice words in memory (power of two)
  localparam int ADR_W     = 6;   // log2(SLICES)
  localparam int LANE_BITS = 25;  // bits per slice word (5x5 plane)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARITY = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Position of lane bit (x,y) inside a slice word.
  function automatic int bit_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/col_parity_theta_mask_gen.sv
// ============================================================================
// theta_mask_gen
// Combinational theta mask for one slice: D[x] = cur[x-1] ^ prev[x+1]
// (indices mod 5), replicated over all five rows y.
// Revision: 1.0
// ============================================================================
`default_nettype none

module theta_mask_gen
  import col_parity_pkg::*;
(
  input  logic [4:0]           cur_par,
  input  logic [4:0]           prev_par,
  output logic [0:LANE_BITS-1] mask
);

  for (genvar x = 0; x < 5; x++) begin : g_col
    for (genvar y = 0; y < 5; y++) begin : g_row
      localparam int IDX = bit_idx(x, y);
      assign mask[IDX] = cur_par[(x + 4) % 5] ^ prev_par[(x + 1) % 5];
    end
  end

endmodule

`default_nettype wire

// File: rtl/col_parity.sv
// ============================================================================
// col_parity
// Keccak theta step over a slice-organised 64x25 state memory. Pass 1 reads
// every slice and records its five column parities; pass 2 rewrites every
// slice XORed with the theta mask, then done is raised until start drops.
// Optional build macro: COL_PARITY_STATUS_EN adds busy and phase outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module col_parity
  import col_parity_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [0:LANE_BITS-1] in,
  output logic                 done,
  output logic [ADR_W-1:0]     mem_adr,
  output logic [0:LANE_BITS-1] mem_in,
  output logic                 mem_r,
  output logic                 mem_w
`ifdef COL_PARITY_STATUS_EN
  ,
  output logic                 busy,
  output logic [1:0]           phase
`endif
);

  localparam logic [ADR_W-1:0] LAST_Z = ADR_W'(SLICES - 1);

  state_t           state;
  logic [ADR_W-1:0] z;
  logic [4:0]       par [SLICES];
  logic [4:0]       slice_par;
  logic [0:LANE_BITS-1] mask;
  logic             active;

  // Column parities of the word currently on the read port.
  always_comb begin
    slice_par = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        slice_par[x] = slice_par[x] ^ in[bit_idx(x, y)];
      end
    end
  end

  // Sequencer: two sweeps of z, then hold done until start is released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      z     <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            state <= PARITY;
            z     <= '0;
          end
        end
        PARITY: begin
          z <= z + ADR_W'(1);
          if (z == LAST_Z) state <= UPDATE;
        end
        UPDATE: begin
          z <= z + ADR_W'(1);
          if (z == LAST_Z) state <= DONE;
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parity store, written once per slice during the first sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLICES; i++) par[i] <= '0;
    end else if (state == PARITY) begin
      par[z] <= slice_par;
    end
  end

  // z-1 wraps naturally on the ADR_W-bit counter, so slice 0 pairs with 63.
  theta_mask_gen u_mask (
    .cur_par  (par[z]),
    .prev_par (par[z - ADR_W'(1)]),
    .mask     (mask)
  );

  assign active  = (state == PARITY) || (state == UPDATE);
  assign mem_r   = active;
  assign mem_w   = (state == UPDATE);
  assign mem_adr = active ? z : '0;
  assign mem_in  = (state == UPDATE) ? (in ^ mask) : '0;

`ifdef COL_PARITY_STATUS_EN
  assign busy  = active;
  assign phase = state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_col_parity.sv
// ============================================================================
// tb_col_parity
// Self-checking bench for col_parity: behavioural memory, golden theta model
// computed from column sums, directed and random memory images.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_col_parity;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [0:24] in_w;
  logic        done;
  logic [5:0]  mem_adr;
  logic [0:24] mem_in;
  logic        mem_r;
  logic        mem_w;
`ifdef COL_PARITY_STATUS_EN
  logic        busy;
  logic [1:0]  phase;
`endif

  logic [0:24] mem  [64];
  logic [0:24] snap [64];
  logic [0:24] gold [64];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  col_parity dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .in      (in_w),
    .done    (done),
    .mem_adr (mem_adr),
    .mem_in  (mem_in),
    .mem_r   (mem_r),
    .mem_w   (mem_w)
`ifdef COL_PARITY_STATUS_EN
    ,
    .busy    (busy),
    .phase   (phase)
`endif
  );

  // Behavioural state memory: combinational read, write on rising edge.
  assign in_w = mem[mem_adr];
  always @(posedge clock) if (mem_w) mem[mem_adr] <= mem_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:24] col_word(input int x);
    logic [0:24] w;
    w = '0;
    for (int y = 0; y < 5; y++) w[x + 5 * y] = 1'b1;
    return w;
  endfunction

  // Golden theta: column sums C[x][z], D[x][z] = C[x-1][z] ^ C[x+1][z-1].
  task automatic compute_gold();
    bit c [5][64];
    bit d;
    for (int z = 0; z < 64; z++) snap[z] = mem[z];
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++) begin
        c[x][z] = 1'b0;
        for (int y = 0; y < 5; y++) c[x][z] ^= snap[z][x + 5 * y];
      end
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++) begin
        d = c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + 63) % 64];
        for (int y = 0; y < 5; y++) gold[z][x + 5 * y] = snap[z][x + 5 * y] ^ d;
      end
  endtask

  task automatic clear_mem();
    for (int z = 0; z < 64; z++) mem[z] = '0;
  endtask

  // One full operation: access sequence, latency, result, done handshake.
  task automatic run_theta(input string name);
    int extra;
    compute_gold();
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 128; k++) begin
      @(negedge clock);
      check({name, "_seq"}, {24'd0, mem_r, mem_w, mem_adr},
            {24'd0, 1'b1, (k >= 64), 6'(k % 64)});
      @(posedge clock);
    end
    @(negedge clock);
    check({name, "_done_early"}, {31'd0, done}, 32'd0);
    extra = 0;
    while (!done && extra < 8) begin
      @(posedge clock);
      @(negedge clock);
      extra++;
    end
    check({name, "_latency"}, extra, 32'd1);
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check({name, "_hold"}, {30'd0, done, mem_r | mem_w}, {30'd0, 1'b1, 1'b0});
    end
    for (int z = 0; z < 64; z++)
      check({name, "_word"}, {7'd0, mem[z]}, {7'd0, gold[z]});
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check({name, "_done_tail"}, {31'd0, done}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    check({name, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [0:24] w;
    clear_mem();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out", {done, mem_r, mem_w, mem_adr, mem_in}, 34'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_out", {done, mem_r, mem_w, mem_adr, mem_in}, 34'd0);

    // All-zero memory.
    run_theta("zero");

    // Single bit in slice 0.
    clear_mem();
    mem[0][0] = 1'b1;
    run_theta("s0");
    w = col_word(1); w[0] = 1'b1;
    check("s0_slice0", {7'd0, mem[0]}, {7'd0, w});
    check("s0_slice1", {7'd0, mem[1]}, {7'd0, col_word(4)});

    // Single bit in slice 63, wrap into slice 0.
    clear_mem();
    mem[63][0] = 1'b1;
    run_theta("s63");
    w = col_word(1); w[0] = 1'b1;
    check("s63_slice63", {7'd0, mem[63]}, {7'd0, w});
    check("s63_slice0", {7'd0, mem[0]}, {7'd0, col_word(4)});

    // Even column parity: unchanged.
    clear_mem();
    mem[5][0] = 1'b1;
    mem[5][5] = 1'b1;
    w = mem[5];
    run_theta("even");
    check("even_slice5", {7'd0, mem[5]}, {7'd0, w});

    // Random images.
    for (int r = 0; r < 3; r++) begin
      for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
      run_theta("rand");
    end

    // Reset in the middle of a run.
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    repeat (70) @(posedge clock);
    #2;
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_out", {done, mem_r, mem_w, mem_adr, mem_in}, 34'd0);
    @(negedge clock) reset = 1'b1;
    seen = 0;
    repeat (200) begin
      @(posedge clock);
      @(negedge clock);
      if (done || mem_r || mem_w) seen++;
    end
    check("midrst_quiet", seen, 32'd0);
    run_theta("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
